// File: rtl/pipelined_adder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder_pkg
//  Description : Shared defaults, operation-mode encoding and a small helper
//                for the segmented pipelined adder.
//  Contents    : DEFAULT_WIDTH / DEFAULT_SEG  - default operand/segment widths
//                OP_ADD / OP_SUB              - encoding of the 'sub' input
//                signed_ovf()                 - two's-complement overflow rule
//  Revision    : 1.0 - initial release
// ============================================================================
package pipelined_adder_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_SEG   = 16;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Overflow when both addends share a sign and the result does not.
   // b_msb must already be the effective (possibly inverted) operand MSB.
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic b_msb,
                                       input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage : pipelined_adder_pkg
`default_nettype wire

// File: rtl/pipelined_adder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder_if
//  Description : Operand/result handshake bundle for pipelined_adder.
//  Signals     : in_valid/in_ready  - operand handshake
//                a, b, cin, sub     - operands, carry-in, add/subtract select
//                out_valid/out_ready- result handshake
//                sum, cout, ovf     - result, carry-out, signed overflow
//  Modports    : master - drives operands, consumes results
//                slave  - the adder itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

endinterface : pipelined_adder_if
`default_nettype wire

// File: rtl/pipelined_adder_adder_seg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : adder_seg
//  Description : Combinational SEG-bit adder slice with carry-in/carry-out.
//  Ports       : a, b  [SEG] - segment operands
//                cin         - carry into the segment
//                sum   [SEG] - segment sum
//                cout        - carry out of the segment MSB
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_seg
   import pipelined_adder_pkg::*;
#(
   parameter int SEG = DEFAULT_SEG
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule : adder_seg
`default_nettype wire

// File: rtl/pipelined_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : WIDTH-bit add/subtract unit split into STAGES = WIDTH/SEG
//                carry-pipelined segments with valid/ready flow control.
//                Stage k adds operand segment k plus the carry from stage
//                k-1 and forwards the partial sum and operands onward.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - pipelined_adder_if.slave (operands in, result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SEG   = DEFAULT_SEG
) (
   input  logic             clk,
   input  logic             rst_n,
   pipelined_adder_if.slave bus
);

   localparam int STAGES = WIDTH / SEG;

   if ((WIDTH % SEG) != 0) begin : g_bad_seg
      $error("pipelined_adder: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
   end

   // Stage inputs: index 0 comes from the bus, index k from stage k-1.
   logic [WIDTH-1:0]            w_a_in [STAGES];
   logic [WIDTH-1:0]            w_b_in [STAGES];
   logic [WIDTH-1:0]            w_s_in [STAGES];
   logic [STAGES-1:0]           w_c_in;
   logic [STAGES-1:0]           w_v_in;
   logic [STAGES-1:0][SEG-1:0]  w_seg_sum;
   logic [STAGES-1:0]           w_seg_cout;
   logic                        w_advance;

   // Stage registers: operands (b already in effective form), partial sum,
   // carry out of the segment just added, and the valid bit.
   logic [WIDTH-1:0]            r_a [STAGES];
   logic [WIDTH-1:0]            r_b [STAGES];
   logic [WIDTH-1:0]            r_s [STAGES];
   logic [STAGES-1:0]           r_c;
   logic [STAGES-1:0]           r_v;

   // One global enable: the whole pipe moves together, so bubbles keep
   // their position and ordering is trivially preserved.
   assign w_advance = !r_v[STAGES-1] || bus.out_ready;

   always_comb begin
      // Subtraction is a + ~b + 1: invert b once at the entry and force the
      // initial carry; later stages see an ordinary addition.
      w_a_in[0] = bus.a;
      w_b_in[0] = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
      w_c_in[0] = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;
      w_s_in[0] = '0;
      w_v_in[0] = bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
         w_a_in[k] = r_a[k-1];
         w_b_in[k] = r_b[k-1];
         w_c_in[k] = r_c[k-1];
         w_s_in[k] = r_s[k-1];
         w_v_in[k] = r_v[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_seg #(
         .SEG (SEG)
      ) u_seg (
         .a    (w_a_in[k][k*SEG +: SEG]),
         .b    (w_b_in[k][k*SEG +: SEG]),
         .cin  (w_c_in[k]),
         .sum  (w_seg_sum[k]),
         .cout (w_seg_cout[k])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v <= '0;
         r_c <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
         end
      end else if (w_advance) begin
         r_v <= w_v_in;
         r_c <= w_seg_cout;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k]                 <= w_a_in[k];
            r_b[k]                 <= w_b_in[k];
            r_s[k]                 <= w_s_in[k];
            r_s[k][k*SEG +: SEG]   <= w_seg_sum[k];
         end
      end
   end

   // Outputs come straight from the last stage registers; only out_ready
   // reaches in_ready combinationally.
   assign bus.in_ready  = w_advance;
   assign bus.out_valid = r_v[STAGES-1];
   assign bus.sum       = r_s[STAGES-1];
   assign bus.cout      = r_c[STAGES-1];
   assign bus.ovf       = signed_ovf(r_a[STAGES-1][WIDTH-1],
                                     r_b[STAGES-1][WIDTH-1],
                                     r_s[STAGES-1][WIDTH-1]);

endmodule : pipelined_adder
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_adder
//  Description : Scoreboard bench for pipelined_adder (WIDTH=32, SEG=16).
//                Stimulus pushes hand-computed expected results on
//                acceptance; a monitor pops and compares on each output
//                transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;
   import pipelined_adder_pkg::*;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   logic clk;
   logic rst_n;
   int   ready_mode;   // 0: hold low, 1: hold high, 2: random
   int   n_checks;
   int   n_pass;
   int   n_pushed;
   int   n_popped;
   res_t exp_q [$];

   pipelined_adder_if #(.WIDTH(32)) bus ();

   pipelined_adder #(
      .WIDTH (32),
      .SEG   (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic res_t model(input logic [31:0] a_v, input logic [31:0] b_v,
                                  input logic cin_v, input logic sub_v);
      logic [32:0] t;
      logic [31:0] be;
      res_t        r;
      be     = sub_v ? ~b_v : b_v;
      t      = {1'b0, a_v} + {1'b0, be} + {32'd0, (sub_v ? 1'b1 : cin_v)};
      r.sum  = t[31:0];
      r.cout = t[32];
      r.ovf  = (a_v[31] == be[31]) && (t[31] != a_v[31]);
      return r;
   endfunction

   // Called at posedge+1; returns at posedge+1 just after acceptance with
   // in_valid still high so a following send streams without a bubble.
   task automatic send(input logic [31:0] a_v, input logic [31:0] b_v,
                       input logic cin_v, input logic sub_v,
                       input logic [31:0] es, input logic ec, input logic eo);
      res_t e;
      bit   acc;
      e.sum = es; e.cout = ec; e.ovf = eo;
      bus.in_valid = 1'b1;
      bus.a = a_v; bus.b = b_v; bus.cin = cin_v; bus.sub = sub_v;
      acc = 1'b0;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (bus.in_ready && rst_n) begin
            exp_q.push_back(e);
            n_pushed++;
            acc = 1'b1;
            break;
         end
      end
      check("accept_timeout", {63'd0, acc}, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = OP_ADD;
   endtask

   task automatic drain(input string name);
      for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
      check(name, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // out_ready driver (sole writer), applied at posedge+2
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: an output transfer happens at the next posedge when both
   // handshake signals are high at the preceding negedge.
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", {30'd0, bus.sum, bus.cout, bus.ovf}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               n_popped++;
               check("result", {30'd0, bus.sum, bus.cout, bus.ovf}, {30'd0, e.sum, e.cout, e.ovf});
            end
         end
      end
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic        rs;
      res_t        r;
      bit          seen;

      n_checks = 0; n_pass = 0; n_pushed = 0; n_popped = 0;
      ready_mode = 1;
      rst_n = 1'b0;
      idle();

      // Reset state
      @(negedge clk);
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_sum",       {32'd0, bus.sum},       64'd0);
      check("rst_cout",      {63'd0, bus.cout},      64'd0);
      check("rst_ovf",       {63'd0, bus.ovf},       64'd0);
      check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors, streamed back-to-back
      send(32'h0000FFFF, 32'h00000001, 1'b0, OP_ADD, 32'h00010000, 1'b0, 1'b0);
      send(32'hFFFFFFFF, 32'h00000000, 1'b1, OP_ADD, 32'h00000000, 1'b1, 1'b0);
      send(32'h80000000, 32'h00000001, 1'b0, OP_SUB, 32'h7FFFFFFF, 1'b1, 1'b1);
      send(32'h00000000, 32'h00000001, 1'b0, OP_SUB, 32'hFFFFFFFF, 1'b0, 1'b0);
      send(32'h7FFFFFFF, 32'h00000001, 1'b0, OP_ADD, 32'h80000000, 1'b0, 1'b1);
      send(32'h12345678, 32'h11111111, 1'b1, OP_ADD, 32'h2345678A, 1'b0, 1'b0);
      send(32'h00000005, 32'h00000005, 1'b1, OP_SUB, 32'h00000000, 1'b1, 1'b0);
      send(32'hFFFF0000, 32'h00010000, 1'b0, OP_ADD, 32'h00000000, 1'b1, 1'b0);
      send(32'h80000000, 32'h80000000, 1'b0, OP_ADD, 32'h00000000, 1'b1, 1'b1);
      send(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, OP_SUB, 32'h80000000, 1'b0, 1'b1);
      send(32'h0000FFFF, 32'h00000000, 1'b1, OP_ADD, 32'h00010000, 1'b0, 1'b0);
      idle();
      drain("drain_directed");

      // Back-pressure: 4 ops, output stalled for 3 cycles after first valid
      ready_mode = 0;
      fork
         begin
            send(32'h00000001, 32'h00000002, 1'b0, OP_ADD, 32'h00000003, 1'b0, 1'b0);
            send(32'h00000010, 32'h00000020, 1'b0, OP_ADD, 32'h00000030, 1'b0, 1'b0);
            send(32'h00000005, 32'h00000003, 1'b0, OP_SUB, 32'h00000002, 1'b1, 1'b0);
            send(32'h7FFFFFFF, 32'h00000001, 1'b0, OP_ADD, 32'h80000000, 1'b0, 1'b1);
            idle();
         end
         begin
            seen = 1'b0;
            for (int t = 0; t < 50; t++) begin
               @(negedge clk);
               if (bus.out_valid) begin
                  seen = 1'b1;
                  break;
               end
            end
            check("stall_seen", {63'd0, seen}, 64'd1);
            for (int i = 0; i < 3; i++) begin
               check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
               check("stall_hold", {30'd0, bus.sum, bus.cout, bus.ovf}, {30'd0, 32'h00000003, 1'b0, 1'b0});
               if (i < 2) @(negedge clk);
            end
            @(posedge clk);
            #1;
            ready_mode = 1;
         end
      join
      drain("drain_stall");

      // Reset with two ops in flight: they must be discarded
      send(32'h00000100, 32'h00000200, 1'b0, OP_ADD, 32'h00000300, 1'b0, 1'b0);
      send(32'h00000400, 32'h00000500, 1'b0, OP_ADD, 32'h00000900, 1'b0, 1'b0);
      rst_n = 1'b0;
      idle();
      n_pushed -= exp_q.size();
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("mid_rst_sum",       {32'd0, bus.sum},       64'd0);
      check("mid_rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_quiet", {63'd0, bus.out_valid}, 64'd0);
      end
      @(posedge clk);
      #1;
      send(32'h0000FFFF, 32'h00000001, 1'b0, OP_ADD, 32'h00010000, 1'b0, 1'b0);
      idle();
      @(negedge clk);
      check("latency_early", {63'd0, bus.out_valid}, 64'd0);
      @(negedge clk);
      check("latency_on_time", {63'd0, bus.out_valid}, 64'd1);
      @(posedge clk);
      #1;
      drain("drain_reset");

      // Random operands, random gaps and random back-pressure
      ready_mode = 2;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk);
            #1;
         end
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFF;
         if ($urandom_range(0, 7) == 0) rb = 32'h80000000;
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         r  = model(ra, rb, rc, rs);
         send(ra, rb, rc, rs, r.sum, r.cout, r.ovf);
      end
      idle();
      ready_mode = 1;
      drain("drain_random");
      check("count_in_out", 64'(n_popped), 64'(n_pushed));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_pipelined_adder
`default_nettype wire
